// File: rtl/i2s_tdm_rx_pkg.sv
// Shared definitions for the I2S/TDM receiver: FSM state encodings and port-width helpers.
// The optional frame checker is enabled in i2s_tdm_rx with I2S_TDM_RX_FRAMECHK_EN.
package i2s_tdm_rx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SKIP  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_PAD   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    // Channel index width; a single-channel build still carries a 1-bit index.
    function automatic int cw_of(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2s_sync_fifo.sv
// Synchronous FIFO with registered first-word-fall-through output and occupancy level.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module i2s_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_n;
    logic [LW-1:0]    level_n;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop && (level != '0);
    assign push_ok = push && (!full || pop_ok);
    assign rptr_n  = rptr + AW'(pop_ok);
    assign level_n = level + LW'(push_ok) - LW'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            wptr  <= wptr + AW'(push_ok);
            rptr  <= rptr_n;
            level <= level_n;
            valid <= (level_n != '0);
            // The new head may be the word being written this cycle.
            if (level_n != '0) dout <= (push_ok && (wptr == rptr_n)) ? push_data : mem[rptr_n];
        end
    end

endmodule

// File: rtl/i2s_tdm_rx.sv
// Slave-mode I2S/TDM receiver: oversampled pins, slot deserialiser FSM, output FIFO stream.
// Define I2S_TDM_RX_FRAMECHK_EN to add the sticky frame_err output.
module i2s_tdm_rx
    import i2s_tdm_rx_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int SLOT_BITS   = 24,
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_DELAY  = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i2s_clk,
    input  logic                            i2s_sync,
    input  logic                            i2s_rx,
    input  logic                            en,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [SAMPLE_BITS-1:0]          m_data,
    output logic [cw_of(CHANNELS)-1:0]      m_chan,
    output logic [lvl_w(FIFO_DEPTH)-1:0]    fifo_level,
    output logic                            overflow,
    input  logic                            overflow_clr,
`ifdef I2S_TDM_RX_FRAMECHK_EN
    output logic                            frame_err,
`endif
    output logic [2:0]                      dbg_state
);
    localparam int CW    = cw_of(CHANNELS);
    localparam int LW    = lvl_w(FIFO_DEPTH);
    localparam int CNT_W = $clog2(((SYNC_DELAY > SLOT_BITS) ? SYNC_DELAY : SLOT_BITS) + 1);

    // Stream handshake: a word transfers on every clk edge where m_valid && m_ready.
    logic [1:0] clk_s, sync_s, rx_s;
    logic       clk_d, sync_prev;
    logic       bit_evt, frame_start, rx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s     <= '0;
            sync_s    <= '0;
            rx_s      <= '0;
            clk_d     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            clk_s  <= {clk_s[0], i2s_clk};
            sync_s <= {sync_s[0], i2s_sync};
            rx_s   <= {rx_s[0], i2s_rx};
            clk_d  <= clk_s[1];
            if (bit_evt) sync_prev <= sync_s[1];
        end
    end

    assign bit_evt     = clk_s[1] & ~clk_d;
    assign frame_start = bit_evt & sync_prev & ~sync_s[1];
    assign rx_bit      = rx_s[1];

    logic [2:0]             state, state_n;
    logic [CNT_W-1:0]       slot_cnt, slot_n, slot_cur, skip_cnt, skip_n;
    logic [CW-1:0]          chan, chan_n, chan_cur;
    logic [SAMPLE_BITS-1:0] shreg, sh_n;
    logic                   take, slot_end, wr_n, wr_q;
    logic [CW+SAMPLE_BITS-1:0] wr_word;

    always_comb begin
        state_n  = state;
        slot_n   = slot_cnt;
        skip_n   = skip_cnt;
        chan_n   = chan;
        sh_n     = shreg;
        slot_cur = slot_cnt;
        chan_cur = chan;
        take     = 1'b0;
        slot_end = 1'b0;
        wr_n     = 1'b0;
        if (!en) begin
            state_n = ST_IDLE;
        end else if (bit_evt) begin
            // Any frame start restarts the frame, discarding a partial word.
            if (frame_start) begin
                slot_cur = '0;
                chan_cur = '0;
                chan_n   = '0;
                slot_n   = '0;
                if (SYNC_DELAY == 0) begin
                    take = 1'b1;
                end else begin
                    state_n = ST_SKIP;
                    skip_n  = CNT_W'(1);
                end
            end else begin
                case (state)
                    ST_SKIP:  if (skip_cnt >= CNT_W'(SYNC_DELAY)) take = 1'b1;
                              else skip_n = skip_cnt + 1'b1;
                    ST_SHIFT: take = 1'b1;
                    ST_PAD:   if (slot_cnt == CNT_W'(SLOT_BITS - 1)) slot_end = 1'b1;
                              else slot_n = slot_cnt + 1'b1;
                    default:  ;
                endcase
            end
            if (take) begin
                sh_n    = shreg << 1;
                sh_n[0] = rx_bit;
                if (slot_cur == CNT_W'(SAMPLE_BITS - 1)) begin
                    wr_n = 1'b1;
                    if (SAMPLE_BITS == SLOT_BITS) begin
                        slot_end = 1'b1;
                    end else begin
                        state_n = ST_PAD;
                        slot_n  = slot_cur + 1'b1;
                    end
                end else begin
                    state_n = ST_SHIFT;
                    slot_n  = slot_cur + 1'b1;
                end
            end
            if (slot_end) begin
                slot_n = '0;
                if (chan_cur == CW'(CHANNELS - 1)) begin
                    state_n = ST_WAIT;
                end else begin
                    chan_n  = chan_cur + 1'b1;
                    state_n = ST_SHIFT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            slot_cnt <= '0;
            skip_cnt <= '0;
            chan     <= '0;
            shreg    <= '0;
            wr_q     <= 1'b0;
            wr_word  <= '0;
        end else begin
            state    <= state_n;
            slot_cnt <= slot_n;
            skip_cnt <= skip_n;
            chan     <= chan_n;
            shreg    <= sh_n;
            wr_q     <= wr_n;
            if (wr_n) wr_word <= {chan_cur, sh_n};
        end
    end

    assign dbg_state = state;

    logic                      pop, fifo_full, drop;
    logic [CW+SAMPLE_BITS-1:0] fifo_dout;

    i2s_sync_fifo #(
        .WIDTH (CW + SAMPLE_BITS),
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_q),
        .push_data (wr_word),
        .pop       (pop),
        .valid     (m_valid),
        .dout      (fifo_dout),
        .level     (fifo_level),
        .full      (fifo_full)
    );

    assign m_chan = fifo_dout[SAMPLE_BITS +: CW];
    assign m_data = fifo_dout[SAMPLE_BITS-1:0];
    assign pop    = m_valid & m_ready;
    assign drop   = wr_q & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

`ifdef I2S_TDM_RX_FRAMECHK_EN
    localparam int WAIT_LIM = 2 * CHANNELS * SLOT_BITS;
    localparam int WW       = $clog2(WAIT_LIM + 2);

    logic [WW-1:0] wait_cnt;
    logic          early;

    assign early = en & frame_start &
                   ((state == ST_SKIP) || (state == ST_SHIFT) || (state == ST_PAD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            if ((state != ST_WAIT) || frame_start || !en) wait_cnt <= '0;
            else if (bit_evt && (wait_cnt <= WW'(WAIT_LIM))) wait_cnt <= wait_cnt + 1'b1;
            if (early || (wait_cnt > WW'(WAIT_LIM))) frame_err <= 1'b1;
            else if (overflow_clr)                   frame_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Directed bench: a default 2-ch I2S receiver and an 8-slot TDM receiver driven from one sequence.
`timescale 1ns/1ps
module tb_i2s_tdm_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_bclk = 1'b0, a_sync = 1'b1, a_rx = 1'b0, a_en = 1'b0, a_ready = 1'b0, a_oclr = 1'b0;
    logic        a_valid, a_ovf;
    logic [15:0] a_data;
    logic [0:0]  a_chan;
    logic [3:0]  a_level;
    logic [2:0]  a_state;

    logic        b_bclk = 1'b0, b_sync = 1'b0, b_rx = 1'b0, b_en = 1'b0, b_ready = 1'b1, b_oclr = 1'b0;
    logic        b_valid, b_ovf;
    logic [23:0] b_data;
    logic [2:0]  b_chan;
    logic [3:0]  b_level;
    logic [2:0]  b_state;
`ifdef I2S_TDM_RX_FRAMECHK_EN
    logic        a_ferr, b_ferr;
`endif

    i2s_tdm_rx u_a (
        .clk(clk), .rst_n(rst_n), .i2s_clk(a_bclk), .i2s_sync(a_sync), .i2s_rx(a_rx), .en(a_en),
        .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data), .m_chan(a_chan),
        .fifo_level(a_level), .overflow(a_ovf), .overflow_clr(a_oclr),
`ifdef I2S_TDM_RX_FRAMECHK_EN
        .frame_err(a_ferr),
`endif
        .dbg_state(a_state)
    );

    i2s_tdm_rx #(.CHANNELS(8), .SLOT_BITS(32), .SAMPLE_BITS(24), .SYNC_DELAY(0), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .i2s_clk(b_bclk), .i2s_sync(b_sync), .i2s_rx(b_rx), .en(b_en),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_chan(b_chan),
        .fifo_level(b_level), .overflow(b_ovf), .overflow_clr(b_oclr),
`ifdef I2S_TDM_RX_FRAMECHK_EN
        .frame_err(b_ferr),
`endif
        .dbg_state(b_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_a[$];
    logic [31:0] got_b[$];

    always @(negedge clk) begin
        if (a_valid && a_ready) got_a.push_back({15'd0, a_chan, a_data});
        if (b_valid && b_ready) got_b.push_back({5'd0, b_chan, b_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_words(input string tag, input bit use_b);
        logic [31:0] g, e;
        int          idx;
        check({tag, "_count"}, use_b ? got_b.size() : got_a.size(), exp_q.size());
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 'x;
            if (use_b) begin
                if (got_b.size() > 0) g = got_b.pop_front();
            end else begin
                if (got_a.size() > 0) g = got_a.pop_front();
            end
            check($sformatf("%s_word%0d", tag, idx), g, e);
            idx++;
        end
        got_a.delete();
        got_b.delete();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ready_a(input logic v);
        @(posedge clk);
        #1 a_ready = v;
    endtask

    task automatic pulse_clr_a();
        @(posedge clk);
        #1 a_oclr = 1'b1;
        @(posedge clk);
        #1 a_oclr = 1'b0;
    endtask

    task automatic bit_a(input logic s, input logic d);
        a_sync = s;
        a_rx   = d;
        #40 a_bclk = 1'b1;
        #40 a_bclk = 1'b0;
    endtask

    task automatic word_a(input logic s, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_a(s, v[i]);
    endtask

    // I2S frame: frame-start bit, left slot (sync low), right slot (sync high), one idle bit.
    task automatic frame_a(input logic [23:0] l, input logic [23:0] r);
        bit_a(1'b0, 1'b0);
        word_a(1'b0, {8'd0, l}, 24);
        word_a(1'b1, {8'd0, r}, 24);
        bit_a(1'b1, 1'b0);
    endtask

    task automatic bit_b(input logic s, input logic d);
        b_sync = s;
        b_rx   = d;
        #40 b_bclk = 1'b1;
        #40 b_bclk = 1'b0;
    endtask

    // TDM frame: one-bit sync pulse, then 8 slots whose 24-bit sample is n<<8 with a nonzero pad.
    task automatic frame_b();
        logic [31:0] slot;
        bit_b(1'b1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            slot = {n[15:0], 8'h00, 8'hA5};
            for (int i = 31; i >= 0; i--) bit_b(1'b0, slot[i]);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 0);
        check("rst_chan", a_chan, 0);
        check("rst_level", a_level, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_state", a_state, 0);
`ifdef I2S_TDM_RX_FRAMECHK_EN
        check("rst_ferr", a_ferr, 0);
`endif
        rst_n = 1'b1;
        a_en  = 1'b1;
        b_en  = 1'b1;
        set_ready_a(1'b1);

        // 1: default 2-channel I2S
        bit_a(1'b1, 1'b0);
        frame_a(24'hA5A5C3, 24'h5A5A3C);
        wait_clks(20);
        exp_q.push_back({15'd0, 1'b0, 16'hA5A5});
        exp_q.push_back({15'd0, 1'b1, 16'h5A5A});
        check_words("t1", 1'b0);

        // 2: 8-slot TDM, left-justified
        frame_b();
        wait_clks(20);
        for (int n = 0; n < 8; n++) exp_q.push_back((n << 24) | (n << 8));
        check_words("t2", 1'b1);

        // 3: consumer stalled for 5 frames
        set_ready_a(1'b0);
        for (int k = 0; k < 5; k++) frame_a({16'h1000 + k[15:0], 8'hFF}, {16'h2000 + k[15:0], 8'h00});
        wait_clks(20);
        check("t3_level", a_level, 8);
        check("t3_ovf", a_ovf, 1);
        check("t3_valid", a_valid, 1);
        check("t3_head", a_data, 16'h1000);
        pulse_clr_a();
        check("t3_ovf_clr", a_ovf, 0);
        set_ready_a(1'b1);
        wait_clks(20);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({15'd0, 1'b0, 16'h1000 + k[15:0]});
            exp_q.push_back({15'd0, 1'b1, 16'h2000 + k[15:0]});
        end
        check_words("t3", 1'b0);

        // 4: early frame start 10 bits into slot 1
        bit_a(1'b0, 1'b0);
        word_a(1'b0, 32'h345678, 24);
        word_a(1'b1, 32'h2DE, 10);
        frame_a(24'h4321AA, 24'h8765BB);
        wait_clks(20);
        exp_q.push_back({15'd0, 1'b0, 16'h3456});
        exp_q.push_back({15'd0, 1'b0, 16'h4321});
        exp_q.push_back({15'd0, 1'b1, 16'h8765});
        check_words("t4", 1'b0);
`ifdef I2S_TDM_RX_FRAMECHK_EN
        check("t4_ferr", a_ferr, 1);
        pulse_clr_a();
        check("t4_ferr_clr", a_ferr, 0);
`endif

        // 5: reset asserted mid-SHIFT with words queued
        set_ready_a(1'b0);
        frame_a(24'h111100, 24'h222200);
        bit_a(1'b0, 1'b0);
        word_a(1'b0, 32'hFFFFFF, 10);
        wait_clks(5);
        check("t5_level_pre", a_level, 2);
        rst_n = 1'b0;
        #1;
        check("t5_valid", a_valid, 0);
        check("t5_data", a_data, 0);
        check("t5_level", a_level, 0);
        check("t5_state", a_state, 0);
        #20 rst_n = 1'b1;
        set_ready_a(1'b1);
        word_a(1'b0, 32'hFFFFFF, 14);
        word_a(1'b1, 32'h0, 24);
        bit_a(1'b1, 1'b0);
        frame_a(24'hBEEF00, 24'hCAFE00);
        wait_clks(20);
        exp_q.push_back({15'd0, 1'b0, 16'hBEEF});
        exp_q.push_back({15'd0, 1'b1, 16'hCAFE});
        check_words("t5", 1'b0);

        // 6: enable dropped mid-frame with 3 words queued
        set_ready_a(1'b0);
        frame_a(24'h333300, 24'h444400);
        bit_a(1'b0, 1'b0);
        word_a(1'b0, 32'h555500, 24);
        word_a(1'b1, 32'h1F, 5);
        a_en = 1'b0;
        word_a(1'b1, 32'h0, 19);
        bit_a(1'b1, 1'b0);
        frame_a(24'h777700, 24'h888800);
        wait_clks(20);
        check("t6_level", a_level, 3);
        set_ready_a(1'b1);
        wait_clks(20);
        exp_q.push_back({15'd0, 1'b0, 16'h3333});
        exp_q.push_back({15'd0, 1'b1, 16'h4444});
        exp_q.push_back({15'd0, 1'b0, 16'h5555});
        check_words("t6_drain", 1'b0);
        a_en = 1'b1;
        frame_a(24'h999900, 24'hAAAA00);
        wait_clks(20);
        exp_q.push_back({15'd0, 1'b0, 16'h9999});
        exp_q.push_back({15'd0, 1'b1, 16'hAAAA});
        check_words("t6_resume", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
